// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, and registered
// press/release/repeat pulses plus a debounced level and a press-toggled state.
module btn_conditioner #(
  parameter int unsigned DB_CYCLES     = 65536,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 25000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic toggle
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    REPEAT,
    DB_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             sync1, sync2;
  state_t           state, state_n;
  state_t           held_from, held_from_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, press_n, release_n, repeat_n, toggle_n;

  // NOTE: every default is assigned before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    held_from_n = held_from;
    cnt_n       = cnt;
    press_n     = 1'b0;
    release_n   = 1'b0;
    repeat_n    = 1'b0;
    toggle_n    = toggle;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (sync2) state_n = DB_PRESS;
      end
      DB_PRESS: begin
        if (!sync2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n  = PRESSED;
          cnt_n    = '0;
          press_n  = 1'b1;
          toggle_n = ~toggle;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_n     = DB_RELEASE;
          cnt_n       = '0;
          held_from_n = PRESSED;
        end else if (cnt == HOLD_LAST) begin
          state_n  = REPEAT;
          cnt_n    = '0;
          repeat_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!sync2) begin
          state_n     = DB_RELEASE;
          cnt_n       = '0;
          held_from_n = REPEAT;
        end else if (cnt == REPEAT_LAST) begin
          cnt_n    = '0;
          repeat_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DB_RELEASE: begin
        // A short low glitch while held resumes the hold and restarts its timing.
        if (sync2) begin
          state_n = held_from;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    level_n = (state_n == PRESSED) || (state_n == REPEAT) || (state_n == DB_RELEASE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= IDLE;
      held_from     <= PRESSED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      sync1         <= btn_raw;
      sync2         <= sync1;
      state         <= state_n;
      held_from     <= held_from_n;
      cnt           <= cnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      repeat_pulse  <= repeat_n;
      toggle        <= toggle_n;
    end
  end

endmodule
